// File: rtl/dmem_access_arbiter.sv
// dmem_access_arbiter
// Shares one single-port data memory between port 0 (pipeline MEM stage) and
// port 1 (debug/program loader). One access per two cycles: an IDLE cycle that
// samples requests and latches the winner, then an ACCESS cycle that drives the
// memory controls. Read data, rvalid and err appear in the cycle after ACCESS.
//
// Optional build macro: DMEM_ARB_ROUND_ROBIN_EN
//   defined   : simultaneous requests alternate (the port that did not win last)
//   undefined : port 0 always wins a tie
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | no memory access; sample requests, latch winner's command
// ST_ACCESS | memory controls driven for the latched command; gnt pulses
module dmem_access_arbiter #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MEM_DEPTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_err,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic                latch_en;
  logic                win_port;
  logic                access;
  logic                in_range;
  logic                lat_we;
  logic                lat_port;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;

  assign access   = (state_q == ST_ACCESS);
  // Unsigned full-width compare; no wrap of large addresses into the array.
  assign in_range = (lat_addr < ADDR_W'(MEM_DEPTH));

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic last_win_q;

  // Remember which port won the most recent grant (reset favours port 0 next).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_win_q <= 1'b1;
    end else if (latch_en) begin
      last_win_q <= win_port;
    end
  end

  // Tie goes to the port that did not win last; otherwise the lone requester.
  always_comb begin
    win_port = 1'b0;
    if (p0_req && p1_req) begin
      win_port = ~last_win_q;
    end else begin
      win_port = ~p0_req;
    end
  end
`else
  // Fixed priority: port 0 whenever it is requesting.
  always_comb begin
    win_port = ~p0_req;
  end
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: any request in IDLE starts an access; ACCESS always lasts one cycle.
  always_comb begin
    state_d  = state_q;
    latch_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (p0_req || p1_req) begin
          state_d  = ST_ACCESS;
          latch_en = 1'b1;
        end
      end
      ST_ACCESS: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Capture the winner's command; these also hold mem_addr/mem_wdata between accesses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_we    <= 1'b0;
      lat_port  <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (latch_en) begin
      lat_port  <= win_port;
      lat_we    <= win_port ? p1_we    : p0_we;
      lat_addr  <= win_port ? p1_addr  : p0_addr;
      lat_wdata <= win_port ? p1_wdata : p0_wdata;
    end
  end

  // Memory controls and grants are pure decodes of the state so reset kills them at once.
  always_comb begin
    busy      = access;
    p0_gnt    = access & ~lat_port;
    p1_gnt    = access &  lat_port;
    mem_addr  = lat_addr;
    mem_wdata = lat_wdata;
    mem_write = access &  lat_we & in_range;
    mem_read  = access & ~lat_we & in_range;
  end

  // Completion: capture read data and raise one-cycle rvalid/err pulses for the granted port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p0_rvalid <= 1'b0;
      p0_err    <= 1'b0;
      p0_rdata  <= '0;
      p1_rvalid <= 1'b0;
      p1_err    <= 1'b0;
      p1_rdata  <= '0;
    end else begin
      p0_rvalid <= 1'b0;
      p0_err    <= 1'b0;
      p1_rvalid <= 1'b0;
      p1_err    <= 1'b0;
      if (access) begin
        if (!lat_port) begin
          p0_rvalid <= ~lat_we;
          p0_err    <= ~in_range;
          if (!lat_we) begin
            p0_rdata <= in_range ? mem_rdata : '0;
          end
        end else begin
          p1_rvalid <= ~lat_we;
          p1_err    <= ~in_range;
          if (!lat_we) begin
            p1_rdata <= in_range ? mem_rdata : '0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_access_arbiter.sv
// Bench for dmem_access_arbiter: directed table of single transactions, hand
// sequences for ties, back-to-back and reset-during-access, then random
// two-port traffic checked against a transaction-level reference model.
// Honours DMEM_ARB_ROUND_ROBIN_EN for the expected tie outcome.
module tb_dmem_access_arbiter;
  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 32;
  localparam int MEM_DEPTH = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic              rq   [2];
  logic              rwe  [2];
  logic [ADDR_W-1:0] raddr[2];
  logic [DATA_W-1:0] rwd  [2];

  wire               p0_req = rq[0], p1_req = rq[1];
  wire               p0_we = rwe[0], p1_we = rwe[1];
  wire  [ADDR_W-1:0] p0_addr = raddr[0], p1_addr = raddr[1];
  wire  [DATA_W-1:0] p0_wdata = rwd[0], p1_wdata = rwd[1];
  logic              p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
  logic [DATA_W-1:0] p0_rdata, p1_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_write, mem_read, busy;
  logic [DATA_W-1:0] mem_rdata = '0;

  dmem_access_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_DEPTH(MEM_DEPTH)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_read(mem_read), .mem_rdata(mem_rdata), .busy(busy)
  );

  // Single-port data memory acting on the falling edge.
  logic [DATA_W-1:0] mem [MEM_DEPTH];
  always @(negedge clk) begin
    if (mem_write && mem_addr < MEM_DEPTH) mem[mem_addr[4:0]] <= mem_wdata;
    if (mem_read && mem_addr < MEM_DEPTH) mem_rdata <= mem[mem_addr[4:0]];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int p, input bit req, input bit we,
                       input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wd);
    rq[p] = req; rwe[p] = we; raddr[p] = addr; rwd[p] = wd;
  endtask

  task automatic do_reset();
    rq[0] = 1'b0; rq[1] = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Tie-break rule stated at transaction level.
  function automatic int pick(input bit r0, input bit r1, input int last);
    if (r0 && r1) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      return 1 - last;
`else
      return 0;
`endif
    end
    return r0 ? 0 : 1;
  endfunction

  // One isolated transaction from IDLE: grant next cycle, response the cycle after.
  task automatic do_txn(input string nm, input int p, input bit we, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] wd, input bit exp_err, input logic [DATA_W-1:0] exp_rd);
    int q;
    q = 1 - p;
    drive(p, 1'b1, we, addr, wd);
    step();
    chk({nm, ".gnt"}, p == 0 ? p0_gnt : p1_gnt, 1);
    chk({nm, ".other_gnt"}, q == 0 ? p0_gnt : p1_gnt, 0);
    chk({nm, ".busy"}, busy, 1);
    chk({nm, ".mem_write"}, mem_write, we && !exp_err);
    chk({nm, ".mem_read"}, mem_read, !we && !exp_err);
    chk({nm, ".mem_addr"}, mem_addr, addr);
    rq[p] = 1'b0;
    step();
    chk({nm, ".busy2"}, busy, 0);
    chk({nm, ".rvalid"}, p == 0 ? p0_rvalid : p1_rvalid, !we);
    chk({nm, ".err"}, p == 0 ? p0_err : p1_err, exp_err);
    chk({nm, ".other_rvalid"}, q == 0 ? p0_rvalid : p1_rvalid, 0);
    if (!we) chk({nm, ".rdata"}, p == 0 ? p0_rdata : p1_rdata, exp_rd);
  endtask

  typedef struct {
    string             name;
    int                port;
    bit                we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    bit                exp_err;
    logic [DATA_W-1:0] exp_rd;
  } vec_t;

  vec_t vecs[$];

  // Reference model state for the random phase.
  logic [DATA_W-1:0] ref_mem [MEM_DEPTH];
  bit                m_acc;
  int                m_port, m_last;
  bit                m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  bit                e_rvalid[2], e_err[2];
  logic [DATA_W-1:0] e_rdata[2];

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int got[$];
    int exp_seq[4];
    int waited;
    bit seen;

    for (int p = 0; p < 2; p++) drive(p, 1'b0, 1'b0, '0, '0);
    do_reset();

    chk("rst.busy", busy, 0);
    chk("rst.gnt", {p0_gnt, p1_gnt}, 0);
    chk("rst.rvalid_err", {p0_rvalid, p1_rvalid, p0_err, p1_err}, 0);
    chk("rst.rdata", {p0_rdata, p1_rdata}, 0);
    chk("rst.mem_ctl", {mem_write, mem_read}, 0);
    chk("rst.mem_addr", mem_addr, 0);

    vecs.push_back('{"w0_10",      0, 1'b1, 32'd0,          32'd10,         1'b0, 32'd0});
    vecs.push_back('{"r0_0",       0, 1'b0, 32'd0,          32'd0,          1'b0, 32'd10});
    vecs.push_back('{"w1_5",       1, 1'b1, 32'd5,          32'hDEADBEEF,   1'b0, 32'd0});
    vecs.push_back('{"r1_5",       1, 1'b0, 32'd5,          32'd0,          1'b0, 32'hDEADBEEF});
    vecs.push_back('{"r0_oor32",   0, 1'b0, 32'd32,         32'd0,          1'b1, 32'd0});
    vecs.push_back('{"w1_oor32",   1, 1'b1, 32'd32,         32'h11111111,   1'b1, 32'd0});
    vecs.push_back('{"w0_31",      0, 1'b1, 32'd31,         32'h00001234,   1'b0, 32'd0});
    vecs.push_back('{"r1_31",      1, 1'b0, 32'd31,         32'd0,          1'b0, 32'h00001234});
    vecs.push_back('{"r1_oormax",  1, 1'b0, 32'hFFFFFFFF,   32'd0,          1'b1, 32'd0});
    vecs.push_back('{"w0_3",       0, 1'b1, 32'd3,          32'h00000055,   1'b0, 32'd0});
    vecs.push_back('{"r1_3",       1, 1'b0, 32'd3,          32'd0,          1'b0, 32'h00000055});
    vecs.push_back('{"r0_5",       0, 1'b0, 32'd5,          32'd0,          1'b0, 32'hDEADBEEF});
    foreach (vecs[i]) do_txn(vecs[i].name, vecs[i].port, vecs[i].we, vecs[i].addr,
                             vecs[i].wdata, vecs[i].exp_err, vecs[i].exp_rd);
    chk("oor_write_no_effect", mem[0], 32'd10);

    // Tie: both ports request continuously.
    do_reset();
    drive(0, 1'b1, 1'b0, 32'd0, '0);
    drive(1, 1'b1, 1'b0, 32'd5, '0);
    for (int i = 0; i < 8; i++) begin
      step();
      if (p0_gnt) got.push_back(0);
      else if (p1_gnt) got.push_back(1);
    end
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    exp_seq = '{0, 1, 0, 1};
`else
    exp_seq = '{0, 0, 0, 0};
`endif
    chk("tie.count", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++) chk("tie.winner", got[i], exp_seq[i]);
    rq[0] = 1'b0;
    seen = 1'b0;
    waited = 0;
    while (!seen && waited < 4) begin
      step();
      waited++;
      if (p1_gnt) seen = 1'b1;
    end
    chk("tie.loser_served", seen, 1);
    rq[1] = 1'b0;
    repeat (2) step();

    // Back-to-back: p0 read and p1 write queued together.
    do_reset();
    drive(0, 1'b1, 1'b0, 32'd5, '0);
    drive(1, 1'b1, 1'b1, 32'd7, 32'hA5A5A5A5);
    step();
    chk("b2b.busy1", busy, 1);
    chk("b2b.p0_gnt", p0_gnt, 1);
    rq[0] = 1'b0;
    step();
    chk("b2b.busy0", busy, 0);
    chk("b2b.p0_rvalid", p0_rvalid, 1);
    chk("b2b.p0_rdata", p0_rdata, 32'hDEADBEEF);
    step();
    chk("b2b.busy1b", busy, 1);
    chk("b2b.p1_gnt", p1_gnt, 1);
    chk("b2b.mem_write", mem_write, 1);
    rq[1] = 1'b0;
    step();
    chk("b2b.p1_rvalid", {p1_rvalid, p1_err}, 0);
    chk("b2b.mem7", mem[7], 32'hA5A5A5A5);

    // Reset during ACCESS, before the negedge that would perform the write.
    drive(1, 1'b1, 1'b1, 32'd3, 32'd7);
    step();
    chk("rma.mem_write_before", mem_write, 1);
    #1 reset = 1'b1;
    #1;
    chk("rma.mem_write_drop", mem_write, 0);
    chk("rma.outputs", {busy, p0_gnt, p1_gnt, mem_read, p1_rvalid, p1_err}, 0);
    chk("rma.mem_addr", mem_addr, 0);
    rq[1] = 1'b0;
    step();
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (p1_gnt || p1_rvalid || p1_err) seen = 1'b1;
    end
    chk("rma.no_late_pulse", seen, 0);
    chk("rma.mem3", mem[3], 32'h55);
    do_txn("rma.readback", 1, 1'b0, 32'd3, '0, 1'b0, 32'h55);

    // Random two-port traffic against the reference model.
    do_reset();
    for (int i = 0; i < MEM_DEPTH; i++) ref_mem[i] = mem[i];
    m_acc = 1'b0; m_last = 1; m_port = 0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
    for (int p = 0; p < 2; p++) begin e_rvalid[p] = 0; e_err[p] = 0; e_rdata[p] = '0; end
    for (int c = 0; c < 3000; c++) begin
      int w;
      step();
      e_rvalid[0] = 0; e_rvalid[1] = 0; e_err[0] = 0; e_err[1] = 0;
      if (m_acc) begin
        if (!m_we) begin
          e_rvalid[m_port] = 1;
          e_rdata[m_port]  = (m_addr < MEM_DEPTH) ? ref_mem[m_addr[4:0]] : '0;
        end
        if (m_addr >= MEM_DEPTH) e_err[m_port] = 1;
        else if (m_we) ref_mem[m_addr[4:0]] = m_wdata;
        m_acc = 1'b0;
      end else if (rq[0] || rq[1]) begin
        w = pick(rq[0], rq[1], m_last);
        m_port = w; m_we = rwe[w]; m_addr = raddr[w]; m_wdata = rwd[w];
        m_last = w; m_acc = 1'b1;
      end
      chk("rnd.busy", busy, m_acc);
      chk("rnd.gnt", {p1_gnt, p0_gnt}, {m_acc && m_port == 1, m_acc && m_port == 0});
      chk("rnd.mem_ctl", {mem_write, mem_read},
          {m_acc && m_we && m_addr < MEM_DEPTH, m_acc && !m_we && m_addr < MEM_DEPTH});
      if (m_acc) chk("rnd.mem_addr", mem_addr, m_addr);
      if (m_acc && m_we) chk("rnd.mem_wdata", mem_wdata, m_wdata);
      chk("rnd.rvalid", {p1_rvalid, p0_rvalid}, {e_rvalid[1], e_rvalid[0]});
      chk("rnd.err", {p1_err, p0_err}, {e_err[1], e_err[0]});
      chk("rnd.p0_rdata", p0_rdata, e_rdata[0]);
      chk("rnd.p1_rdata", p1_rdata, e_rdata[1]);
      for (int p = 0; p < 2; p++) begin
        if (m_acc && m_port == p) rq[p] = 1'b0;
        else if (!rq[p] && c < 2990 && $urandom_range(0, 2) == 0) begin
          drive(p, 1'b1, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 9) == 0) ? 32'($urandom) : 32'($urandom_range(0, 39)),
                32'($urandom));
        end
      end
    end
    for (int i = 0; i < MEM_DEPTH; i++) chk("rnd.final_mem", mem[i], ref_mem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
